laser_frame_sequencer: RTL and testbench

Front/back-end sequencer for the LASER coverage core. It accepts target points from the host over a valid/ready stream and buffers them in a ping-pong pair of 40-point banks. It bursts each complete frame into the core's X/Y port under control of a core-reset line (L_RST), then captures the core's C1/C2 result on DONE into a 2-entry result FIFO drained by the host. This lets the next frame load while the current one computes.

---
 rtl/laser_frame_sequencer.sv | 177 +++++++++++++++++
 tb/tb_laser_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_frame_sequencer.sv
// Ping-pong point buffer and frame sequencer for the LASER coverage core:
// loads host points, bursts full frames to the core and queues its results.
module laser_frame_sequencer #(
    parameter int NPTS = 40
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  PX,
    input  logic [3:0]  PY,
    input  logic        P_VALID,
    output logic        P_READY,
    output logic [3:0]  X,
    output logic [3:0]  Y,
    output logic        L_RST,
    input  logic [3:0]  C1X,
    input  logic [3:0]  C1Y,
    input  logic [3:0]  C2X,
    input  logic [3:0]  C2Y,
    input  logic        DONE,
    output logic [15:0] R_DATA,
    output logic        R_VALID,
    input  logic        R_READY
);
    localparam int IW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int AW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(NPTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RUN} state_t;
    typedef enum logic [1:0] {B_EMPTY, B_FULL, B_STREAMING} bank_st_t;

    state_t        state_q, state_d;
    bank_st_t      bank_st_q [2];
    bank_st_t      bank_st_d [2];
    logic          wb_q, wb_d, rb_q, rb_d;
    logic [IW-1:0] wi_q, wi_d, si_q, si_d;
    logic          l_rst_q, l_rst_d;
    logic [15:0]   fifo_q [2];
    logic [15:0]   fifo_d [2];
    logic          fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    // Both banks share one RAM; the bank select is the address MSB.
    logic [7:0]    mem [2**AW];
    logic [7:0]    xy_q;

    logic          accept, fill_done, push, pop, start, stream_end, rd_en;
    logic [IW-1:0] rd_idx;
    logic [AW-1:0] rd_addr;

    assign P_READY = (bank_st_q[wb_q] == B_EMPTY);
    assign R_VALID = (fifo_cnt_q != 2'd0);
    assign R_DATA  = R_VALID ? fifo_q[fifo_rp_q] : 16'h0;
    assign X       = xy_q[7:4];
    assign Y       = xy_q[3:0];
    assign L_RST   = l_rst_q;

    assign accept     = P_VALID && P_READY;
    assign fill_done  = accept && (wi_q == LAST);
    assign pop        = R_VALID && R_READY;
    assign push       = (state_q == S_RUN) && DONE;
    // Start only if the result slot will be free by the time this frame finishes.
    assign start      = (state_q == S_IDLE) && (bank_st_q[rb_q] == B_FULL) &&
                        ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop));
    assign stream_end = (state_q == S_STREAM) && (si_q == LAST);
    assign rd_en      = start || ((state_q == S_STREAM) && !stream_end);
    assign rd_idx     = start ? '0 : si_q + IW'(1);
    assign rd_addr    = {rb_q, rd_idx};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign bank_st_d[gi] = (fill_done && (wb_q == 1'(gi)))  ? B_FULL :
                                   (start && (rb_q == 1'(gi)))      ? B_STREAMING :
                                   (stream_end && (rb_q == 1'(gi))) ? B_EMPTY :
                                   bank_st_q[gi];
            assign fifo_d[gi] = (push && (fifo_wp_q == 1'(gi))) ? {C1X, C1Y, C2X, C2Y}
                                                                  : fifo_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        si_d       = si_q;
        rb_d       = rb_q;
        l_rst_d    = l_rst_q;
        wi_d       = wi_q;
        wb_d       = wb_q;
        fifo_wp_d  = fifo_wp_q ^ push;
        fifo_rp_d  = fifo_rp_q ^ pop;
        fifo_cnt_d = fifo_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    si_d    = '0;
                    l_rst_d = 1'b0;
                end
            end
            S_STREAM: begin
                if (stream_end) begin
                    state_d = S_RUN;
                    si_d    = '0;
                    rb_d    = ~rb_q;
                end else begin
                    si_d = si_q + IW'(1);
                end
            end
            S_RUN: begin
                if (DONE) begin
                    state_d = S_IDLE;
                    l_rst_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                l_rst_d = 1'b1;
            end
        endcase

        if (accept) begin
            if (wi_q == LAST) begin
                wi_d = '0;
                wb_d = ~wb_q;
            end else begin
                wi_d = wi_q + IW'(1);
            end
        end

        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wi_q       <= '0;
            si_q       <= '0;
            l_rst_q    <= 1'b1;
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                bank_st_q[i] <= B_EMPTY;
                fifo_q[i]    <= 16'h0;
            end
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wi_q       <= wi_d;
            si_q       <= si_d;
            l_rst_q    <= l_rst_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
            bank_st_q  <= bank_st_d;
            fifo_q     <= fifo_d;
        end
    end

    // Registered RAM read doubles as the X/Y output register; it reads zero outside STREAM.
    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            mem[{wb_q, wi_q}] <= {PX, PY};
        end
        if (RST || !rd_en) begin
            xy_q <= 8'h0;
        end else begin
            xy_q <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_laser_frame_sequencer.sv
// Bench for laser_frame_sequencer: a frame/queue level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_laser_frame_sequencer;
    localparam int NPTS = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  PX = 4'h0, PY = 4'h0;
    logic        P_VALID = 1'b0;
    logic        P_READY;
    logic [3:0]  X, Y;
    logic        L_RST;
    logic [3:0]  C1X = 4'h0, C1Y = 4'h0, C2X = 4'h0, C2Y = 4'h0;
    logic        DONE = 1'b0;
    logic [15:0] R_DATA;
    logic        R_VALID;
    logic        R_READY = 1'b0;

    laser_frame_sequencer #(.NPTS(NPTS)) dut (
        .CLK(CLK), .RST(RST), .PX(PX), .PY(PY), .P_VALID(P_VALID), .P_READY(P_READY),
        .X(X), .Y(Y), .L_RST(L_RST), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .DONE(DONE), .R_DATA(R_DATA), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    always #5 CLK = ~CLK;

    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    logic [7:0] last_frame [NPTS];

    // Model: phase 0 idle, 1 streaming point m_k of the oldest held frame, 2 waiting for DONE.
    int          m_phase = 0;
    int          m_k = 0;
    logic [7:0]  m_held [$];
    logic [7:0]  m_part [$];
    logic [15:0] m_res  [$];

    always @(negedge CLK) begin : model_cmp
        logic [26:0] exp_v, act_v;
        logic        e_pready, e_lrst, e_rvalid;
        logic [7:0]  e_xy;
        logic [15:0] e_rdata;
        bit          pop, start_ok, acc;
        int          frames;

        frames   = m_held.size() / NPTS;
        e_pready = (frames < 2);
        e_lrst   = (m_phase == 0);
        e_rvalid = (m_res.size() > 0);
        e_rdata  = e_rvalid ? m_res[0] : 16'h0;
        e_xy     = (m_phase == 1) ? m_held[m_k] : 8'h0;
        exp_v    = {e_pready, e_lrst, e_rvalid, e_xy, e_rdata};
        act_v    = {P_READY, L_RST, R_VALID, X, Y, R_DATA};
        if (chk_en) begin
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL cycle %0d outputs {P_READY,L_RST,R_VALID,X,Y,R_DATA}: got %h, required %h",
                         cyc, act_v, exp_v);
            end
        end

        cyc++;
        if (RST) begin
            m_phase = 0;
            m_k     = 0;
            m_held.delete();
            m_part.delete();
            m_res.delete();
        end else begin
            pop      = e_rvalid && R_READY;
            start_ok = (m_phase == 0) && (frames >= 1) && ((m_res.size() - (pop ? 1 : 0)) == 0);
            acc      = P_VALID && e_pready;
            case (m_phase)
                0: if (start_ok) begin
                    m_phase = 1;
                    m_k     = 0;
                end
                1: if (m_k == NPTS - 1) begin
                    m_phase = 2;
                    repeat (NPTS) void'(m_held.pop_front());
                end else begin
                    m_k++;
                end
                default: if (DONE) begin
                    m_res.push_back({C1X, C1Y, C2X, C2Y});
                    m_phase = 0;
                end
            endcase
            if (pop) void'(m_res.pop_front());
            if (acc) begin
                m_part.push_back({PX, PY});
                if (m_part.size() == NPTS) begin
                    foreach (m_part[i]) m_held.push_back(m_part[i]);
                    m_part.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Offers points until NPTS are accepted; returns in the cycle after the last accept.
    task automatic load_frame(input int valid_pct);
        int got = 0;
        int budget = 0;
        while (got < NPTS && budget < 2000) begin
            P_VALID = ($urandom_range(0, 99) < valid_pct);
            PX = 4'($urandom);
            PY = 4'($urandom);
            @(negedge CLK);
            if (P_VALID && P_READY) begin
                last_frame[got] = {PX, PY};
                got++;
            end
            budget++;
            tick();
        end
        P_VALID = 1'b0;
        if (got < NPTS) begin
            miscompares++;
            $display("FAIL load_timeout: accepted %0d points, required %0d", got, NPTS);
        end
    endtask

    task automatic set_c(input logic [15:0] c);
        {C1X, C1Y, C2X, C2Y} = c;
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);
        check("reset_state", 32'({P_READY, L_RST, R_VALID, X, Y, R_DATA}),
              32'({1'b1, 1'b1, 1'b0, 8'h00, 16'h0000}));

        // Single frame, stub core answers 100 cycles after L_RST falls
        tick();
        load_frame(100);
        @(negedge CLK);
        check("idle_dwell_lrst", 32'(L_RST), 32'(1'b1));
        tick();
        @(negedge CLK);
        check("single_point0", 32'({L_RST, X, Y}), 32'({1'b0, last_frame[0]}));
        repeat (100) tick();
        set_c(16'h34AC);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        @(negedge CLK);
        check("single_result", 32'({R_VALID, L_RST, R_DATA}), 32'({1'b1, 1'b1, 16'h34AC}));
        tick();
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
        @(negedge CLK);
        check("single_popped", 32'(R_VALID), 32'(1'b0));

        // Back-to-back frames with the host always draining
        tick();
        R_READY = 1'b1;
        load_frame(100);
        load_frame(100);
        repeat (3) tick();
        set_c(16'h1234);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        @(negedge CLK);
        check("b2b_result_a", 32'({R_VALID, L_RST, R_DATA}), 32'({1'b1, 1'b1, 16'h1234}));
        tick();
        @(negedge CLK);
        check("b2b_b_point0", 32'({L_RST, X, Y}), 32'({1'b0, last_frame[0]}));
        repeat (45) tick();
        set_c(16'h5678);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        @(negedge CLK);
        check("b2b_result_b", 32'({R_VALID, R_DATA}), 32'({1'b1, 16'h5678}));

        // Result backpressure with three frames offered
        tick();
        R_READY = 1'b0;
        set_c(16'h9ABC);
        DONE = 1'b1;
        load_frame(100);
        load_frame(100);
        load_frame(100);
        repeat (5) tick();
        @(negedge CLK);
        check("bp_hold", 32'({R_VALID, L_RST, P_READY, R_DATA}), 32'({1'b1, 1'b1, 1'b0, 16'h9ABC}));
        tick();
        DONE = 1'b0;
        R_READY = 1'b1;
        @(negedge CLK);
        check("bp_drain_head", 32'(R_DATA), 32'(16'h9ABC));
        tick();
        R_READY = 1'b0;
        @(negedge CLK);
        check("bp_next_start", 32'({L_RST, R_VALID}), 32'({1'b0, 1'b0}));

        // Reset at stream point 20
        repeat (20) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_stream", 32'({P_READY, L_RST, R_VALID, X, Y, R_DATA}),
              32'({1'b1, 1'b1, 1'b0, 8'h00, 16'h0000}));

        // Reset while waiting for DONE
        tick();
        R_READY = 1'b1;
        load_frame(100);
        repeat (45) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_in_run", 32'({P_READY, L_RST, R_VALID, X, Y, R_DATA}),
              32'({1'b1, 1'b1, 1'b0, 8'h00, 16'h0000}));

        // Fresh frame with host gaps; spurious DONE in IDLE and STREAM
        tick();
        load_frame(55);
        DONE = 1'b1;
        set_c(16'hFEDC);
        @(negedge CLK);
        check("spurious_idle_lrst", 32'(L_RST), 32'(1'b1));
        tick();
        @(negedge CLK);
        check("gap_frame_point0", 32'({L_RST, X, Y, R_VALID}), 32'({1'b0, last_frame[0], 1'b0}));
        repeat (3) tick();
        DONE = 1'b0;
        repeat (60) tick();
        set_c(16'h0F1E);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        @(negedge CLK);
        check("gap_frame_result", 32'({R_VALID, R_DATA}), 32'({1'b1, 16'h0F1E}));

        // Randomized traffic, including occasional resets
        for (int n = 0; n < 4000; n++) begin
            tick();
            P_VALID = ($urandom_range(0, 99) < 60);
            PX      = 4'($urandom);
            PY      = 4'($urandom);
            R_READY = ($urandom_range(0, 1) == 1);
            DONE    = ($urandom_range(0, 11) == 0);
            set_c(16'($urandom));
            RST     = ($urandom_range(0, 1499) == 0);
        end
        tick();
        RST = 1'b0;
        P_VALID = 1'b0;
        DONE = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
